// File: rtl/btn_debounce.sv
// ============================================================================
//  Module      : btn_debounce
//  Description : Synchronizes the raw pushbutton on PIN_6 into the CLK domain
//                and debounces it, producing a clean level plus single-cycle
//                press and release strobes for downstream clock-enable use.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 160000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic PIN_6,
    output logic BTN_LEVEL,
    output logic BTN_PRESS,
    output logic BTN_RELEASE
);

    localparam int CNT_W = (DEBOUNCE_CYCLES + 1 > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    // Terminal count: the Nth consecutive mismatching sample commits the change.
    localparam logic [CNT_W-1:0] c_term = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync_q;
    logic                   r_level;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_press;
    logic                   r_release;

    assign w_sync_q = r_sync[SYNC_STAGES-1];

    // Metastability chain; PIN_6 is read only by the first flop.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], PIN_6};
        end
    end

    // Debounce counter: count consecutive mismatches, commit level at terminal count.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_level   <= 1'b0;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (w_sync_q == r_level) begin
                // Any return to the stable level restarts the run.
                r_cnt <= '0;
            end else if (r_cnt == c_term) begin
                r_level   <= w_sync_q;
                r_cnt     <= '0;
                r_press   <= w_sync_q;
                r_release <= ~w_sync_q;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign BTN_LEVEL   = r_level;
    assign BTN_PRESS   = r_press;
    assign BTN_RELEASE = r_release;

endmodule

`default_nettype wire

// File: tb/tb_btn_debounce.sv
// ============================================================================
//  Module      : tb_btn_debounce
//  Description : Self-checking bench for btn_debounce. Two instances run on
//                the same stimulus (S=2/D=4 and S=3/D=1); a per-edge model
//                pushes expected outputs to a queue that is popped and
//                compared after each edge, plus directed event checks.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btn_debounce;

    localparam int c_s0 = 2;
    localparam int c_d0 = 4;
    localparam int c_s1 = 3;
    localparam int c_d1 = 1;

    logic clk = 1'b0;
    logic rst_n;
    logic pin;
    logic lvl0, prs0, rel0;
    logic lvl1, prs1, rel1;

    int n_total = 0;
    int n_bad   = 0;

    // Model state, one slot per instance.
    int          c_s [2] = '{c_s0, c_s1};
    int          c_d [2] = '{c_d0, c_d1};
    logic [7:0]  m_pipe  [2];
    logic [63:0] m_hist  [2];
    int          m_n     [2];
    logic        m_level [2];
    logic        m_press [2];
    logic        m_rel   [2];

    logic [5:0] exp_q[$];

    // Directed event bookkeeping for the S=2/D=4 instance.
    int edge_i;
    int n_press;
    int n_rel;
    int first_press;
    int first_rel;

    btn_debounce #(.DEBOUNCE_CYCLES(c_d0), .SYNC_STAGES(c_s0)) dut0 (
        .CLK        (clk),
        .RST_N      (rst_n),
        .PIN_6      (pin),
        .BTN_LEVEL  (lvl0),
        .BTN_PRESS  (prs0),
        .BTN_RELEASE(rel0)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(c_d1), .SYNC_STAGES(c_s1)) dut1 (
        .CLK        (clk),
        .RST_N      (rst_n),
        .PIN_6      (pin),
        .BTN_LEVEL  (lvl1),
        .BTN_PRESS  (prs1),
        .BTN_RELEASE(rel1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (edge %0d, t=%0t)", tag, got, exp, edge_i, $time);
        end
    endtask

    // Expected outputs after the coming edge: the level flips once the last
    // D synchronized samples since the previous commit all differ from it.
    task automatic model_edge(input int k, input logic p, input logic rn);
        logic        sq;
        logic [63:0] mask;
        m_press[k] = 1'b0;
        m_rel[k]   = 1'b0;
        if (!rn) begin
            m_pipe[k]  = '0;
            m_hist[k]  = '0;
            m_n[k]     = 0;
            m_level[k] = 1'b0;
        end else begin
            sq        = m_pipe[k][c_s[k]-1];
            m_pipe[k] = {m_pipe[k][6:0], p};
            m_hist[k] = {m_hist[k][62:0], sq};
            if (m_n[k] < 64) m_n[k]++;
            mask = (64'd1 << c_d[k]) - 64'd1;
            if (m_n[k] >= c_d[k] && ((m_hist[k] ^ {64{~m_level[k]}}) & mask) == 64'd0) begin
                m_level[k] = sq;
                m_press[k] = sq;
                m_rel[k]   = ~sq;
                m_n[k]     = 0;
            end
        end
    endtask

    task automatic scen_begin();
        edge_i      = 0;
        n_press     = 0;
        n_rel       = 0;
        first_press = -1;
        first_rel   = -1;
    endtask

    // One clock: drive inputs at negedge, predict, then compare #1 after the edge.
    task automatic step(input logic p, input logic rn, input int n);
        logic [5:0] e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pin   = p;
            rst_n = rn;
            model_edge(0, p, rn);
            model_edge(1, p, rn);
            exp_q.push_back({m_level[0], m_press[0], m_rel[0], m_level[1], m_press[1], m_rel[1]});
            @(posedge clk);
            #1;
            edge_i++;
            e = exp_q.pop_front();
            chk("s2d4_out", {29'd0, lvl0, prs0, rel0}, {29'd0, e[5:3]});
            chk("s3d1_out", {29'd0, lvl1, prs1, rel1}, {29'd0, e[2:0]});
            if (prs0) begin
                n_press++;
                if (first_press < 0) first_press = edge_i;
            end
            if (rel0) begin
                n_rel++;
                if (first_rel < 0) first_rel = edge_i;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        pin   = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_pipe[k] = '0; m_hist[k] = '0; m_n[k] = 0;
            m_level[k] = 1'b0; m_press[k] = 1'b0; m_rel[k] = 1'b0;
        end
        scen_begin();

        // Reset held 3 cycles with the button pressed: outputs stay 0.
        step(1'b1, 1'b0, 3);
        chk("reset_level", {31'd0, lvl0}, 32'd0);
        chk("reset_press", {31'd0, prs0}, 32'd0);
        chk("reset_rel",   {31'd0, rel0}, 32'd0);
        // Held through release: a fresh press at the 6th edge.
        scen_begin();
        step(1'b1, 1'b1, 10);
        chk("rst_press_edge", first_press, 6);
        chk("rst_press_cnt",  n_press, 1);
        chk("rst_level",      {31'd0, lvl0}, 32'd1);

        // Release held: one release strobe 6 edges later.
        scen_begin();
        step(1'b0, 1'b1, 10);
        chk("rel_edge", first_rel, 6);
        chk("rel_cnt",  n_rel, 1);

        // Clean press.
        scen_begin();
        step(1'b1, 1'b1, 10);
        chk("press_edge", first_press, 6);
        chk("press_cnt",  n_press, 1);
        step(1'b0, 1'b1, 10);

        // Bounce 1,0,1,0 in runs of 3, then settle high.
        scen_begin();
        step(1'b1, 1'b1, 3);
        step(1'b0, 1'b1, 3);
        step(1'b1, 1'b1, 3);
        step(1'b0, 1'b1, 3);
        chk("bounce_quiet", n_press + n_rel, 0);
        step(1'b1, 1'b1, 10);
        chk("bounce_press_edge", first_press, 18);
        chk("bounce_press_cnt",  n_press, 1);
        chk("bounce_rel_cnt",    n_rel, 0);
        step(1'b0, 1'b1, 10);

        // Three-cycle glitch from idle: no activity.
        scen_begin();
        step(1'b1, 1'b1, 3);
        step(1'b0, 1'b1, 10);
        chk("glitch_press", n_press, 0);
        chk("glitch_rel",   n_rel, 0);
        chk("glitch_level", {31'd0, lvl0}, 32'd0);

        // Reset pulsed at E4 mid-count: press 6 edges after reset returns high.
        scen_begin();
        step(1'b1, 1'b1, 3);
        step(1'b1, 1'b0, 1);
        step(1'b1, 1'b1, 10);
        chk("midrst_press_edge", first_press, 10);
        chk("midrst_press_cnt",  n_press, 1);

        // Random chatter with occasional long holds, model-checked every edge.
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 1)), 1'b1, $urandom_range(1, 6));
        end
        step(1'b0, 1'b1, 10);

        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
